// File: rtl/psram_pkg.sv
// Shared types for the PSRAM front end: arbiter FSM states, grant owners, bus widths.
// Pure declarations; no timing or flow-control behaviour of its own.
package psram_pkg;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        RESPOND   = 3'd4
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_CPU  = 2'd2
    } owner_t;

endpackage

// File: rtl/psram_arbiter.sv
// Two-client (video/CPU) single-word arbiter in front of the PSRAM QPI controller; ack = 4 + controller busy-to-done cycles.
// One transaction in flight; requests are held by clients until ack, and nothing is issued until the controller is ready.
module psram_arbiter
    import psram_pkg::*;
#(
    parameter int VIDEO_RUN_MAX = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_vid_req,
    input  logic [ADDR_W-1:0] i_vid_addr,
    output logic              o_vid_ack,
    output logic [DATA_W-1:0] o_vid_data,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_din,
    output logic              o_cpu_ack,
    output logic [DATA_W-1:0] o_cpu_data,
    output logic              o_mem_stb,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_din,
    input  logic              i_mem_busy,
    input  logic              i_mem_done,
    input  logic [DATA_W-1:0] i_mem_dout
);

    localparam logic [3:0] RUN_MAX = 4'(VIDEO_RUN_MAX);

    arb_state_t        r_state;
    owner_t            r_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_din;
    logic [DATA_W-1:0] r_vid_data;
    logic [DATA_W-1:0] r_cpu_data;
    logic [3:0]        r_run;

    logic w_ready;
    logic w_cpu_wins;

    // Done is sticky, so busy must also be low to know the controller is truly idle.
    assign w_ready    = i_mem_done & ~i_mem_busy;
    assign w_cpu_wins = i_cpu_req & (~i_vid_req | (r_run == RUN_MAX));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_owner    <= OWN_NONE;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_din      <= '0;
            r_vid_data <= '0;
            r_cpu_data <= '0;
            r_run      <= 4'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_ready && (i_vid_req || i_cpu_req)) begin
                        r_state <= ISSUE;
                        if (w_cpu_wins) begin
                            r_owner <= OWN_CPU;
                            r_we    <= i_cpu_we;
                            r_addr  <= i_cpu_addr;
                            r_din   <= i_cpu_din;
                            r_run   <= 4'd0;
                        end else begin
                            r_owner <= OWN_VID;
                            r_we    <= 1'b0;
                            r_addr  <= i_vid_addr;
                            r_din   <= '0;
                            // Only consecutive video wins against a waiting CPU count towards the guard.
                            if (!i_cpu_req)
                                r_run <= 4'd0;
                            else if (r_run != RUN_MAX)
                                r_run <= r_run + 4'd1;
                        end
                    end
                end
                ISSUE: r_state <= WAIT_BUSY;
                WAIT_BUSY: begin
                    if (i_mem_busy)
                        r_state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (i_mem_done) begin
                        r_state <= RESPOND;
                        if (!r_we) begin
                            if (r_owner == OWN_VID)
                                r_vid_data <= i_mem_dout;
                            else
                                r_cpu_data <= i_mem_dout;
                        end
                    end
                end
                RESPOND: begin
                    r_state <= IDLE;
                    r_owner <= OWN_NONE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_mem_stb  = (r_state == ISSUE);
    assign o_mem_we   = r_we;
    assign o_mem_addr = r_addr;
    assign o_mem_din  = r_din;
    assign o_vid_ack  = (r_state == RESPOND) && (r_owner == OWN_VID);
    assign o_cpu_ack  = (r_state == RESPOND) && (r_owner == OWN_CPU);
    assign o_vid_data = r_vid_data;
    assign o_cpu_data = r_cpu_data;

endmodule

// File: tb/tb_psram_arbiter.sv
// Directed bench for psram_arbiter with a behavioural controller of programmable busy length.
module tb_psram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vid_req;
    logic [23:0] vid_addr;
    logic        vid_ack;
    logic [15:0] vid_data;
    logic        cpu_req;
    logic        cpu_we;
    logic [23:0] cpu_addr;
    logic [15:0] cpu_din;
    logic        cpu_ack;
    logic [15:0] cpu_data;
    logic        mem_stb;
    logic        mem_we;
    logic [23:0] mem_addr;
    logic [15:0] mem_din;
    logic        mem_busy;
    logic        mem_done;
    logic [15:0] mem_dout;

    always #5 clk = ~clk;

    psram_arbiter #(.VIDEO_RUN_MAX(4)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_vid_req  (vid_req),
        .i_vid_addr (vid_addr),
        .o_vid_ack  (vid_ack),
        .o_vid_data (vid_data),
        .i_cpu_req  (cpu_req),
        .i_cpu_we   (cpu_we),
        .i_cpu_addr (cpu_addr),
        .i_cpu_din  (cpu_din),
        .o_cpu_ack  (cpu_ack),
        .o_cpu_data (cpu_data),
        .o_mem_stb  (mem_stb),
        .o_mem_we   (mem_we),
        .o_mem_addr (mem_addr),
        .o_mem_din  (mem_din),
        .i_mem_busy (mem_busy),
        .i_mem_done (mem_done),
        .i_mem_dout (mem_dout)
    );

    function automatic logic [15:0] patt(input logic [23:0] a);
        return a[15:0] ^ 16'hA55A;
    endfunction

    // Controller model: busy rises the edge after the strobe, stays high for 'lat' cycles, then done rises.
    int          lat;
    logic        pwr_up;
    int          cnt;
    logic        pend_we;
    logic [23:0] pend_addr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_busy <= 1'b0;
            mem_done <= 1'b0;
            mem_dout <= '0;
            cnt      <= 0;
        end else if (mem_stb) begin
            mem_busy  <= 1'b1;
            mem_done  <= 1'b0;
            cnt       <= lat;
            pend_we   <= mem_we;
            pend_addr <= mem_addr;
        end else if (mem_busy) begin
            if (cnt <= 1) begin
                mem_busy <= 1'b0;
                mem_done <= 1'b1;
                if (!pend_we)
                    mem_dout <= patt(pend_addr);
            end else begin
                cnt <= cnt - 1;
            end
        end else if (pwr_up && !mem_done) begin
            mem_done <= 1'b1;
        end
    end

    int          stb_cnt = 0;
    int          cpu_ack_cnt = 0;
    int          overlap = 0;
    logic        last_we;
    logic [23:0] last_addr;
    logic [15:0] last_din;

    always @(posedge clk) begin
        if (mem_stb) begin
            stb_cnt   <= stb_cnt + 1;
            last_we   <= mem_we;
            last_addr <= mem_addr;
            last_din  <= mem_din;
        end
        if (cpu_ack)
            cpu_ack_cnt <= cpu_ack_cnt + 1;
        if (mem_stb && (cpu_ack || vid_ack))
            overlap <= overlap + 1;
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Latency counts the request cycle itself as cycle 1.
    task automatic wait_ack(input bit is_cpu, input int budget, output int lat_out, output bit ok);
        lat_out = 1;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            lat_out++;
            if (is_cpu ? cpu_ack : vid_ack) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int          l;
        bit          ok;
        int          n;
        int          s0;
        int          a0;
        int          nack;
        int          ncpu;
        logic [15:0] ord;

        rst_n = 1'b1;
        vid_req = 1'b0; vid_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
        pwr_up = 1'b0;
        lat = 3;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_stb",      mem_stb,  0);
        chk("rst_vid_ack",  vid_ack,  0);
        chk("rst_cpu_ack",  cpu_ack,  0);
        chk("rst_mem_we",   mem_we,   0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_din",  mem_din,  0);
        chk("rst_vid_data", vid_data, 0);
        chk("rst_cpu_data", cpu_data, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Controller not ready: a pending CPU read must not strobe.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 24'h000010;
        repeat (1000) @(negedge clk);
        chk("nr_no_stb", stb_cnt, 0);
        chk("nr_no_ack", cpu_ack_cnt, 0);
        pwr_up = 1'b1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n++;
            if (mem_stb) break;
        end
        chk("nr_stb_delay", n, 2);
        wait_ack(1'b1, 100, l, ok);
        chk("nr_ack_seen", ok, 1);
        chk("nr_cpu_data", cpu_data, patt(24'h000010));
        cpu_req = 1'b0;

        // CPU write.
        @(negedge clk);
        s0 = stb_cnt;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 24'h012345; cpu_din = 16'hBEEF;
        wait_ack(1'b1, 100, l, ok);
        chk("wr_ack_seen", ok, 1);
        chk("wr_latency", l, 4 + 3);
        chk("wr_stb_count", stb_cnt - s0, 1);
        chk("wr_mem_we", last_we, 1);
        chk("wr_mem_addr", last_addr, 24'h012345);
        chk("wr_mem_din", last_din, 16'hBEEF);
        chk("wr_cpu_data_held", cpu_data, patt(24'h000010));
        cpu_req = 1'b0; cpu_we = 1'b0;
        @(negedge clk);
        chk("wr_ack_one_cycle", cpu_ack, 0);

        // Video read.
        lat = 5;
        @(negedge clk);
        vid_req = 1'b1; vid_addr = 24'h100000;
        wait_ack(1'b0, 100, l, ok);
        chk("vr_ack_seen", ok, 1);
        chk("vr_latency", l, 4 + 5);
        chk("vr_vid_data", vid_data, 16'hA55A);
        chk("vr_mem_we", last_we, 0);
        vid_req = 1'b0;

        // Simultaneous requests: video first, CPU next, both acked.
        lat = 2;
        @(negedge clk);
        vid_req = 1'b1; vid_addr = 24'h000300;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 24'h000200;
        ord = '0; nack = 0;
        for (int i = 0; i < 200 && (vid_req || cpu_req); i++) begin
            @(negedge clk);
            if (vid_ack) begin ord = {ord[14:0], 1'b0}; nack++; vid_req = 1'b0; end
            if (cpu_ack) begin ord = {ord[14:0], 1'b1}; nack++; cpu_req = 1'b0; end
        end
        chk("sim_ack_count", nack, 2);
        chk("sim_order", ord, 16'h0001);
        chk("sim_vid_data", vid_data, 16'hA65A);
        chk("sim_cpu_data", cpu_data, 16'hA75A);

        // Starvation guard: expected grant order V,V,V,V,C,V,V,V,V,C.
        lat = 1;
        @(negedge clk);
        vid_req = 1'b1; vid_addr = 24'h000500;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 24'h000400;
        ord = '0; nack = 0; ncpu = 0;
        for (int i = 0; i < 400 && ncpu < 2; i++) begin
            @(negedge clk);
            if (vid_ack) begin ord = {ord[14:0], 1'b0}; nack++; end
            if (cpu_ack) begin ord = {ord[14:0], 1'b1}; nack++; ncpu++; end
        end
        vid_req = 1'b0; cpu_req = 1'b0;
        chk("stv_ack_count", nack, 10);
        chk("stv_order", ord, 16'h0021);

        // Reset while the controller is busy with a CPU write.
        lat = 5;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 24'h000777; cpu_din = 16'h1234;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_busy) begin ok = 1'b1; break; end
        end
        chk("rm_busy_seen", ok, 1);
        @(negedge clk);
        a0 = cpu_ack_cnt;
        rst_n = 1'b0;
        #1;
        chk("rm_stb",      mem_stb,  0);
        chk("rm_mem_we",   mem_we,   0);
        chk("rm_mem_addr", mem_addr, 0);
        chk("rm_mem_din",  mem_din,  0);
        chk("rm_cpu_ack",  cpu_ack,  0);
        chk("rm_vid_ack",  vid_ack,  0);
        chk("rm_vid_data", vid_data, 0);
        chk("rm_cpu_data", cpu_data, 0);
        @(negedge clk);
        cpu_req = 1'b0; cpu_we = 1'b0;
        s0 = stb_cnt;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("rm_no_ack_after", cpu_ack_cnt, a0);
        chk("rm_no_stb_after", stb_cnt, s0);
        vid_req = 1'b1; vid_addr = 24'h000042;
        wait_ack(1'b0, 100, l, ok);
        chk("rm_new_ack_seen", ok, 1);
        chk("rm_new_latency", l, 4 + 5);
        chk("rm_new_vid_data", vid_data, 16'hA518);
        vid_req = 1'b0;

        repeat (3) @(negedge clk);
        chk("ack_stb_overlap", overlap, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/psram_arbiter.md
# psram_arbiter

Two-client request arbiter that sits directly upstream of the PSRAM QPI controller and is the only block that drives its strobe, address and data inputs. It accepts single 16-bit word requests from the video line-fetch client (read-only, high priority) and the CPU bus client (read/write). It serialises them into one controller transaction at a time and returns read data and completion to the owning client. A starvation guard keeps continuous video traffic from locking out the CPU.

## Interface
Parameters:
- VIDEO_RUN_MAX, 4: maximum consecutive video grants while a CPU request is pending; range 1–15.

Ports:
- i_clk  in  1  system clock, 100 MHz
- i_rst_n  in  1  asynchronous reset, active low
- i_vid_req  in  1  video read request, level, held until ack
- i_vid_addr  in  24  video word address
- o_vid_ack  out  1  one-cycle pulse; o_vid_data valid this cycle
- o_vid_data  out  16  video read data
- i_cpu_req  in  1  CPU request, level, held until ack
- i_cpu_we  in  1  1 = write, 0 = read
- i_cpu_addr  in  24  CPU word address
- i_cpu_din  in  16  CPU write data
- o_cpu_ack  out  1  one-cycle pulse on completion; o_cpu_data valid on reads
- o_cpu_data  out  16  CPU read data
- o_mem_stb  out  1  controller strobe, one-cycle pulse
- o_mem_we  out  1  controller write enable
- o_mem_addr  out  24  controller address
- o_mem_din  out  16  controller write data
- i_mem_busy  in  1  controller busy
- i_mem_done  in  1  controller done, level, sticky until next strobe
- i_mem_dout  in  16  controller read data

## Operation
- **Reset values:** all outputs 0, state IDLE, video run count 0, grant owner none.
- **Controller ready:** i_mem_done=1 and i_mem_busy=0. No strobe is issued otherwise. This also blocks traffic during controller power-up and QPI entry.
- **States:**
  - IDLE: if ready and any request is pending, choose an owner. Latch owner, we (video forces 0), addr and din into registers. Go to ISSUE.
  - ISSUE: o_mem_stb=1 for exactly one cycle, with o_mem_we/addr/din driven from the latched registers. Go to WAIT_BUSY.
  - WAIT_BUSY: wait for i_mem_busy=1, then go to WAIT_DONE.
  - WAIT_DONE: wait for i_mem_done=1. On a read, capture i_mem_dout into the owner's data register. Go to RESPOND.
  - RESPOND: pulse the owner's ack for one cycle, then return to IDLE.
- **Arbitration:**
  - Video wins by default.
  - If the CPU is pending and the run count equals VIDEO_RUN_MAX, the CPU wins.
  - The run count increments on a video grant while the CPU is pending; it saturates at VIDEO_RUN_MAX.
  - The run count clears on a CPU grant and whenever the CPU is not pending at grant time.
- **Simultaneous requests:** resolved only by the rules above. The losing request stays pending, with no ack and no loss.
- **Request stability:** requests are sampled only in IDLE. Request and address changes after the grant have no effect on the transaction in flight.
- **Request deasserted before ack:** the transaction still completes and ack still pulses. Clients must not withdraw requests.
- **o_vid_data / o_cpu_data:** hold their last captured value until the next read for that client.
- **Reset mid-transaction:** the arbiter returns to reset values immediately and the transaction is abandoned with no ack. The controller is reset by the same system reset.

## Timing
- Arbiter overhead is 3 cycles beyond the controller: grant (IDLE), ISSUE, and RESPOND.
- WAIT_BUSY is normally 1 cycle.
- Latency from request (controller ready) to ack = 4 + controller cycles from busy rise to done rise.
- A back-to-back request for the same client held high is re-granted in the cycle after RESPOND, provided the controller is ready.
- Ack never coincides with o_mem_stb.
- At most one outstanding controller transaction at any time.

## Structure
- Shared package psram_pkg:
  - arbiter state enum (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESPOND)
  - owner enum (OWN_NONE, OWN_VID, OWN_CPU)
  - address/data width constants (24, 16)
- No RTL sub-module; the arbiter is a single FSM with latch registers.
- The bench uses a behavioural controller model that drives busy/done with a programmable latency.

## Test plan
- **CPU write:** controller ready, CPU write addr 0x012345 data 0xBEEF → one o_mem_stb with we=1, addr 0x012345, din 0xBEEF; o_cpu_ack 1 cycle after done.
- **Video read:** model returns 0xA55A → o_vid_data=0xA55A coincident with o_vid_ack; latency = 4 + model latency.
- **Simultaneous requests:** video and CPU request in the same cycle → video served first, CPU served next; no lost ack.
- **Starvation guard:** video held continuously and CPU pending, VIDEO_RUN_MAX=4 → grant order V,V,V,V,C,V,V,V,V,C.
- **Not ready:** i_mem_done=0 after reset, request pending 1000 cycles → no strobe; done rises → strobe within 2 cycles.
- **Reset mid-transaction:** i_rst_n low during WAIT_DONE → all outputs 0 asynchronously; no ack after release; new request served normally.
